cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Single-port memory arbiter sitting directly downstream of the instruction and data caches. Accepts word-granular read requests from the icache and read/write requests from the dcache, grants one at a time to the shared RAM port, and returns data and wait handshakes to each cache. The dcache has priority, and a bounded starvation counter guarantees icache forward progress.

## Interface
- STARVE_MAX, 4, consecutive dcache grants allowed while icache is pending before icache is forced through.
- ERRCNT_W, 8, width of the saturating RAM-error counter.

- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address (word_t)
- iwait  out  1  icache stall; low for exactly the completing cycle
- iload  out  32  icache read data, valid when iREN & !iwait
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; low for exactly the completing cycle
- dload  out  32  dcache read data, valid when dREN & !dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_errs  out  ERRCNT_W  saturating count of ERROR cycles

## Operation
- FSM states (arb_state_t): ARB_IDLE, ARB_IGNT, ARB_DGNT.
- ARB_IDLE: RAM strobes low. Next state: ARB_IGNT if iREN & (starve_cnt == STARVE_MAX); else ARB_DGNT if dREN|dWEN; else ARB_IGNT if iREN; else stay.
- ARB_IGNT: ramREN=1, ramaddr=iaddr. ramstate==ACCESS -> iwait=0, iload=ramload, next ARB_IDLE.
- ARB_DGNT: ramaddr=daddr, ramstore=dstore; dWEN -> ramWEN=1, ramREN=0 (write wins if both asserted); else ramREN=1. ramstate==ACCESS -> dwait=0, dload=ramload, next ARB_IDLE.
- FREE/BUSY in a grant state: hold strobes, wait stays high.
- ERROR in a grant state: hold strobes (retry), wait stays high, ram_errs += 1 (saturates at all-ones).
- Granted requester drops its request before ACCESS (abort): strobes drop combinationally that cycle, next state ARB_IDLE, no completion and no counter change.
- Wait outputs are combinational: iwait = iREN & !(IGNT & ACCESS); dwait = (dREN|dWEN) & !(DGNT & ACCESS). Waits are low when the requester is idle.
- Requesters hold address/data/strobes stable until their wait goes low.
- starve_cnt: on dcache completion with iREN high, +1 (saturating at STARVE_MAX); on icache completion or any cycle with iREN low, cleared to 0.
- load outputs are routed from ramload whenever the matching grant is active, 0 otherwise.

## Timing
- Request at cycle n in ARB_IDLE -> strobes at n+1; earliest completion (wait low) at n+1 if ramstate==ACCESS at n+1.
- Back-to-back: one ARB_IDLE bubble cycle between consecutive grants; minimum 2 cycles per access.
- RST high at an edge: state ARB_IDLE, starve_cnt=0, ram_errs=0; outputs after reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0; waits follow the combinational rule (high if a request is present). Reset mid-grant aborts with no completion.
- Simultaneous iREN and dREN in ARB_IDLE with starve_cnt<STARVE_MAX: dcache granted.

## Structure
- Add to caches_pkg: arb_state_t enum (2 bits: ARB_IDLE, ARB_IGNT, ARB_DGNT) and STARVE_MAX default constant; reuse word_t and ramstate_t.
- Single module, no sub-module; both counters inline.

## Test plan
- iREN, iaddr=0x40, ramstate ACCESS at first grant cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 at n+1; iwait=0, iload=0xDEADBEEF at n+1; IDLE at n+2.
- iREN and dWEN together, daddr=0x80, dstore=0x1234 -> dcache granted first (ramWEN=1, ramaddr=0x80, ramstore=0x1234), icache completes on following grant after a one-cycle IDLE bubble.
- iREN held high, dREN reasserted after every completion, STARVE_MAX=4 -> exactly 4 dcache completions, then icache granted; starve_cnt returns to 0.
- DGNT with ramstate BUSY 3 cycles, ERROR 2 cycles, then ACCESS -> strobes stable throughout, dwait high until ACCESS, ram_errs=2.
- dREN and dWEN both high -> ramWEN=1, ramREN=0.
- RST asserted during ARB_DGNT with ramstate BUSY -> next cycle ramREN=ramWEN=0, state IDLE, ram_errs=0, no dwait-low pulse.

Source files
------------

// File: rtl/caches_pkg.sv
// ----------------------------------------------------------------------------
// caches_pkg
//   Shared types and constants for the cache / memory subsystem.
//   Holds the data word type and the RAM status encoding. It also holds the
//   arbiter FSM state type and default arbiter constants.
// ----------------------------------------------------------------------------
package caches_pkg;

    // Word-granular data/address type used by both caches and the RAM port.
    typedef logic [31:0] word_t;

    // Status reported by the RAM each cycle for the currently strobed access.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter grant states: nobody, icache, dcache.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IGNT = 2'd1,
        ARB_DGNT = 2'd2
    } arb_state_t;

    // Consecutive dcache grants tolerated while the icache waits.
    localparam int STARVE_MAX_DFLT = 4;

    // Default width of the saturating RAM-error counter.
    localparam int ERRCNT_W_DFLT = 8;

endpackage : caches_pkg

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
//   Arbitrates one shared single-port RAM between the instruction cache
//   (read only) and the data cache (read/write). The dcache normally wins.
//   A starvation counter forces the icache through after STARVE_MAX
//   consecutive dcache completions that happened while the icache waited.
//
//   Ports
//     CLK, RST          clock (rising edge), synchronous active-high reset
//     iREN, iaddr       icache read request and word address
//     iwait, iload      icache stall (low on the completing cycle), read data
//     dREN, dWEN        dcache read / write request (write wins if both)
//     daddr, dstore     dcache word address and write data
//     dwait, dload      dcache stall (low on the completing cycle), read data
//     ramREN, ramWEN    RAM read / write strobes
//     ramaddr, ramstore RAM address and write data
//     ramload           RAM read data
//     ramstate          RAM status: FREE, BUSY, ACCESS, ERROR
//     ram_errs          saturating count of ERROR cycles seen on a live grant
//
//   Strobes, waits and loads are combinational from the grant state and the
//   live request lines. A requester that drops its request mid-grant takes
//   the strobes down in the same cycle.
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import caches_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DFLT,
    parameter int ERRCNT_W   = ERRCNT_W_DFLT
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic                iREN,
    input  word_t               iaddr,
    output logic                iwait,
    output word_t               iload,

    input  logic                dREN,
    input  logic                dWEN,
    input  word_t               daddr,
    input  word_t               dstore,
    output logic                dwait,
    output word_t               dload,

    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate,

    output logic [ERRCNT_W-1:0] ram_errs
);

    // Enough bits to hold 0..STARVE_MAX inclusive.
    localparam int                   STARVE_W     = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]  STARVE_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [ERRCNT_W-1:0]  ERRCNT_SAT   = {ERRCNT_W{1'b1}};
    localparam logic [ERRCNT_W-1:0]  ERRCNT_ONE   = ERRCNT_W'(1);
    localparam logic [STARVE_W-1:0]  STARVE_ONE   = STARVE_W'(1);

    arb_state_t             state_r;
    arb_state_t             state_nxt_s;
    logic [STARVE_W-1:0]    starve_cnt_r;
    logic [ERRCNT_W-1:0]    ram_errs_r;

    logic                   d_req_s;
    logic                   i_live_s;
    logic                   d_live_s;
    logic                   ram_access_s;
    logic                   i_done_s;
    logic                   d_done_s;
    logic                   ram_err_s;
    logic                   starved_s;

    // A grant is "live" only while its owner still asserts the request; this
    // is what makes an abort drop the strobes in the same cycle.
    assign d_req_s      = dREN | dWEN;
    assign i_live_s     = (state_r == ARB_IGNT) & iREN;
    assign d_live_s     = (state_r == ARB_DGNT) & d_req_s;
    assign ram_access_s = (ramstate == ACCESS);
    assign i_done_s     = i_live_s & ram_access_s;
    assign d_done_s     = d_live_s & ram_access_s;
    assign ram_err_s    = (i_live_s | d_live_s) & (ramstate == ERROR);
    assign starved_s    = (starve_cnt_r == STARVE_LIMIT);

    // Waits depend only on whether the request completes this cycle.
    assign iwait    = iREN    & ~i_done_s;
    assign dwait    = d_req_s & ~d_done_s;
    assign ram_errs = ram_errs_r;

    // RAM port and load routing for the current grant.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        iload    = 32'h0000_0000;
        dload    = 32'h0000_0000;
        case (state_r)
            ARB_IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
            end
            ARB_DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (dWEN) begin
                    // Write has precedence when both strobes are presented.
                    ramWEN = 1'b1;
                    ramREN = 1'b0;
                end else begin
                    ramWEN = 1'b0;
                    ramREN = dREN;
                end
            end
            default: begin
                ramREN = 1'b0;
                ramWEN = 1'b0;
            end
        endcase
    end

    // Grant selection: a starved icache beats the dcache, otherwise dcache first.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (iREN & starved_s) begin
                    state_nxt_s = ARB_IGNT;
                end else if (d_req_s) begin
                    state_nxt_s = ARB_DGNT;
                end else if (iREN) begin
                    state_nxt_s = ARB_IGNT;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_IGNT: begin
                // Leave on completion or on abort; both pass through IDLE.
                if (~iREN | ram_access_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_IGNT;
                end
            end
            ARB_DGNT: begin
                if (~d_req_s | ram_access_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DGNT;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Grant state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Starvation counter: counts dcache completions while icache is waiting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (~iREN | i_done_s) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (d_done_s & ~starved_s) begin
            starve_cnt_r <= starve_cnt_r + STARVE_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Saturating count of ERROR responses on a live grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_errs_r <= {ERRCNT_W{1'b0}};
        end else if (ram_err_s & (ram_errs_r != ERRCNT_SAT)) begin
            ram_errs_r <= ram_errs_r + ERRCNT_ONE;
        end else begin
            ram_errs_r <= ram_errs_r;
        end
    end

endmodule : cache_mem_arbiter
